// File: rtl/rename_commit_sequencer.sv
// Commit buffer between the ROB commit port and rename_stage. It delivers one commit
// per cycle and sequences mispredict drain, rollback and a fixed recovery stall.
package rename_commit_pkg;
  localparam int PHYS_REG_W = 6;

  typedef struct packed {
    logic                  w_v;
    logic [PHYS_REG_W-1:0] alloc_reg;
    logic [PHYS_REG_W-1:0] freed_reg;
  } commit_rename_t;

  localparam int COMMIT_RENAME_WIDTH = $bits(commit_rename_t);
endpackage

module rename_commit_sequencer
  import rename_commit_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           rob_commit_v_i,
  input  logic [COMMIT_RENAME_WIDTH-1:0] rob_commit_i,
  input  logic                           rob_mispredict_i,
  output logic                           rob_commit_ready_o,
  output logic                           commit_v_o,
  output logic [COMMIT_RENAME_WIDTH-1:0] commit_rename_o,
  output logic                           mispredict_o,
  output logic                           rename_stall_o,
  output logic                           flush_o,
  output logic [1:0]                     state_dbg_o
);
  // Handshake: a record transfers on a cycle where rob_commit_v_i and
  // rob_commit_ready_o are both high; ready never depends on valid.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, RECOVER = 2'd2} state_e;

  state_e                         state, state_n;
  logic [RC_W-1:0]                rc, rc_n;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]               count;
  logic [COMMIT_RENAME_WIDTH:0]   mem [DEPTH];
  logic [COMMIT_RENAME_WIDTH:0]   head;
  logic                           push, pop, pop_mis;

  always_comb begin
    head               = mem[rd_ptr];
    rob_commit_ready_o = !reset_i && (count != CNT_W'(DEPTH)) && (state == IDLE);
    push               = rob_commit_v_i && rob_commit_ready_o;
    pop                = !reset_i && (count != '0) && (state != RECOVER);
    pop_mis            = pop && head[COMMIT_RENAME_WIDTH];
    commit_v_o         = pop;
    commit_rename_o    = pop ? head[COMMIT_RENAME_WIDTH-1:0] : '0;
    mispredict_o       = pop_mis;
    flush_o            = pop_mis;
    rename_stall_o     = !reset_i && ((state != IDLE) || pop_mis);
    state_dbg_o        = state;
  end

  // The rollback pop wins over a new mispredict push; ready is low after any
  // mispredict push, so both cannot be pending at once.
  always_comb begin
    state_n = state;
    rc_n    = rc;
    case (state)
      IDLE: begin
        if (pop_mis) begin
          state_n = RECOVER;
          rc_n    = RC_W'(RECOVER_CYCLES - 1);
        end else if (push && rob_mispredict_i) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_mis) begin
          state_n = RECOVER;
          rc_n    = RC_W'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (rc == '0) state_n = IDLE;
        else          rc_n    = rc - RC_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      rc     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {rob_mispredict_i, rob_commit_i};
  end
endmodule

// File: tb/tb_rename_commit_sequencer.sv
// Bench for rename_commit_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle-by-cycle expectations.
module tb_rename_commit_sequencer;
  import rename_commit_pkg::*;

  localparam int DEPTH = 4;
  localparam int RC    = 2;
  localparam int W     = COMMIT_RENAME_WIDTH;
  localparam int LOGN  = 1024;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         rob_commit_v_i;
  logic [W-1:0] rob_commit_i;
  logic         rob_mispredict_i;
  logic         rob_commit_ready_o;
  logic         commit_v_o;
  logic [W-1:0] commit_rename_o;
  logic         mispredict_o;
  logic         rename_stall_o;
  logic         flush_o;
  logic [1:0]   state_dbg_o;

  rename_commit_sequencer #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .rob_commit_v_i     (rob_commit_v_i),
    .rob_commit_i       (rob_commit_i),
    .rob_mispredict_i   (rob_mispredict_i),
    .rob_commit_ready_o (rob_commit_ready_o),
    .commit_v_o         (commit_v_o),
    .commit_rename_o    (commit_rename_o),
    .mispredict_o       (mispredict_o),
    .rename_stall_o     (rename_stall_o),
    .flush_o            (flush_o),
    .state_dbg_o        (state_dbg_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: buffered records, an outstanding-mispredict flag and the
  // number of recovery stall cycles still owed.
  logic [W:0] exp_q[$];
  bit         pending = 1'b0;
  int         stall_left = 0;
  int         cyc = 0;
  int         n_flush = 0, n_mis_acc = 0, n_commit = 0, n_acc = 0;
  logic         log_v[LOGN], log_flush[LOGN], log_stall[LOGN], log_ready[LOGN];
  logic [W-1:0] log_rec[LOGN];

  always @(negedge clk) begin
    logic         e_ready, e_v, e_mis, e_stall;
    logic [W-1:0] e_rec;
    if (reset_i) begin
      check("reset_ready", 32'(rob_commit_ready_o), 32'd0);
      check("reset_v", 32'(commit_v_o), 32'd0);
      check("reset_rec", 32'(commit_rename_o), 32'd0);
      check("reset_mis", 32'(mispredict_o), 32'd0);
      check("reset_stall", 32'(rename_stall_o), 32'd0);
      check("reset_flush", 32'(flush_o), 32'd0);
      exp_q.delete();
      pending    = 1'b0;
      stall_left = 0;
    end else begin
      e_v     = (exp_q.size() > 0) && (stall_left == 0);
      e_ready = (exp_q.size() < DEPTH) && !pending && (stall_left == 0);
      e_rec   = e_v ? exp_q[0][W-1:0] : '0;
      e_mis   = e_v && exp_q[0][W];
      e_stall = pending || (stall_left > 0) || e_mis;
      check("ready", 32'(rob_commit_ready_o), 32'(e_ready));
      check("commit_v", 32'(commit_v_o), 32'(e_v));
      check("commit_rec", 32'(commit_rename_o), 32'(e_rec));
      check("mispredict", 32'(mispredict_o), 32'(e_mis));
      check("flush", 32'(flush_o), 32'(e_mis));
      check("stall", 32'(rename_stall_o), 32'(e_stall));
      if (commit_v_o) n_commit++;
      if (flush_o) n_flush++;
      if (stall_left > 0) stall_left--;
      if (e_v) begin
        if (exp_q[0][W]) begin
          stall_left = RC;
          pending    = 1'b0;
        end
        void'(exp_q.pop_front());
      end
      if (rob_commit_v_i && e_ready) begin
        exp_q.push_back({rob_mispredict_i, rob_commit_i});
        n_acc++;
        if (rob_mispredict_i) begin
          pending = 1'b1;
          n_mis_acc++;
        end
      end
    end
    if (cyc < LOGN) begin
      log_v[cyc]     = commit_v_o;
      log_flush[cyc] = flush_o;
      log_stall[cyc] = rename_stall_o;
      log_ready[cyc] = rob_commit_ready_o;
      log_rec[cyc]   = commit_rename_o;
    end
    cyc++;
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [W-1:0] rec, input logic mis);
    rob_commit_v_i   = v;
    rob_commit_i     = rec;
    rob_mispredict_i = mis;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  logic [W-1:0] rec_a, rec_b, rec_c, rec_m, rec_m2;
  int t0, tr, nready;

  initial begin
    rec_a  = {1'b1, 6'd3, 6'd10};
    rec_b  = {1'b1, 6'd4, 6'd11};
    rec_c  = {1'b0, 6'd5, 6'd12};
    rec_m  = {1'b1, 6'd7, 6'd13};
    rec_m2 = {1'b1, 6'd8, 6'd14};
    reset_i          = 1'b1;
    rob_commit_v_i   = 1'b0;
    rob_commit_i     = '0;
    rob_mispredict_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    t0 = cyc;
    idle(1);
    check("ready_after_reset", 32'(log_ready[t0]), 32'd1);

    // Plain in-order commits
    t0 = cyc;
    drive(1'b1, rec_a, 1'b0);
    drive(1'b1, rec_b, 1'b0);
    drive(1'b1, rec_c, 1'b0);
    idle(2);
    check("t1_no_bypass", 32'(log_v[t0]), 32'd0);
    check("t1_rec_a", 32'(log_rec[t0+1]), 32'(rec_a));
    check("t1_rec_b", 32'(log_rec[t0+2]), 32'(rec_b));
    check("t1_rec_c", 32'(log_rec[t0+3]), 32'(rec_c));
    check("t1_v3", 32'(log_v[t0+3]), 32'd1);
    check("t1_empty", 32'(log_v[t0+4]), 32'd0);
    check("t1_stall", 32'(log_stall[t0+2]), 32'd0);

    // Continuous stream, pointers wrap several times
    t0 = cyc;
    for (int i = 0; i < 10; i++) drive(1'b1, {1'b1, 6'(i), 6'(i + 20)}, 1'b0);
    idle(2);
    nready = 0;
    for (int i = 0; i < 10; i++) nready += int'(log_ready[t0+i]);
    check("t2_ready_cycles", 32'(nready), 32'd10);
    check("t2_last_rec", 32'(log_rec[t0+10]), 32'({1'b1, 6'd9, 6'd29}));

    // Drain older commits then rollback
    t0 = cyc;
    drive(1'b1, rec_a, 1'b0);
    drive(1'b1, rec_b, 1'b0);
    drive(1'b1, rec_m, 1'b1);
    idle(5);
    check("t3_rec_a", 32'(log_rec[t0+1]), 32'(rec_a));
    check("t3_rec_b", 32'(log_rec[t0+2]), 32'(rec_b));
    check("t3_stall2", 32'(log_stall[t0+2]), 32'd0);
    check("t3_ready3", 32'(log_ready[t0+3]), 32'd0);
    check("t3_flush3", 32'(log_flush[t0+3]), 32'd1);
    check("t3_rec_m", 32'(log_rec[t0+3]), 32'(rec_m));
    for (int k = 3; k <= 5; k++) check("t3_stall_win", 32'(log_stall[t0+k]), 32'd1);
    check("t3_stall6", 32'(log_stall[t0+6]), 32'd0);
    check("t3_ready6", 32'(log_ready[t0+6]), 32'd1);

    // Mispredict into an empty buffer
    t0 = cyc;
    drive(1'b1, rec_m2, 1'b1);
    idle(5);
    check("t4_ready1", 32'(log_ready[t0+1]), 32'd0);
    check("t4_flush1", 32'(log_flush[t0+1]), 32'd1);
    for (int k = 1; k <= 3; k++) check("t4_stall_win", 32'(log_stall[t0+k]), 32'd1);
    check("t4_stall4", 32'(log_stall[t0+4]), 32'd0);
    check("t4_ready4", 32'(log_ready[t0+4]), 32'd1);

    // Reset in the middle of recovery
    drive(1'b1, rec_a, 1'b0);
    drive(1'b1, rec_b, 1'b0);
    drive(1'b1, rec_m, 1'b1);
    idle(1);
    tr = cyc;
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
    t0 = cyc;
    idle(2);
    check("t5_reset_flush", 32'(log_flush[tr]), 32'd0);
    check("t5_reset_stall", 32'(log_stall[tr]), 32'd0);
    check("t5_ready_after", 32'(log_ready[t0]), 32'd1);
    check("t5_stall_after", 32'(log_stall[t0]), 32'd0);
    check("t5_empty_after", 32'(log_v[t0]), 32'd0);

    // Mixed traffic with occasional mispredicts
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 7) == 0));
    idle(10);
    check("t6_flush_count", 32'(n_flush), 32'(n_mis_acc));
    check("t6_commit_count", 32'(n_commit), 32'(n_acc));
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
